hestoneuro_mul_arb: RTL and testbench
=====================================

// Module: hestonEuro_mul_arb
//
// PURPOSE
// - Shares one unsigned 15x15->30 multiplier between NUM_REQ requesters in the hestonEuro datapath.
// - Round-robin arbitration; one product issued per cycle at most; single result port tagged with requester id.
// - Replaces per-loop multiplier instances where throughput allows, saving DSPs.
//
// PARAMETERS
// - NUM_REQ   4   number of requesters (2..8)
// - ID_W      2   width of rsp_id, equal to clog2(NUM_REQ)
// - OP_W      15  operand width (unsigned)
// - RES_W     30  product width, equal to 2*OP_W
//
// PORTS
// - ap_clk    in   1              clock
// - ap_rst    in   1              synchronous reset, active-high
// - req_vld   in   NUM_REQ        per-requester operand valid
// - req_rdy   out  NUM_REQ        per-requester accept (one-hot or zero)
// - req_a     in   NUM_REQ*OP_W   operand A; slot i is bits [i*OP_W +: OP_W]
// - req_b     in   NUM_REQ*OP_W   operand B; same packing as req_a
// - rsp_vld   out  1              result valid
// - rsp_rdy   in   1              result consumer ready
// - rsp_id    out  ID_W           index of the requester owning rsp_data
// - rsp_data  out  RES_W          unsigned product {0,a}*{0,b}, zero-extended, no truncation
// - busy      out  1              high while any result is in flight or held
//
// BEHAVIOUR
// - Reset: rsp_vld=0, rsp_id=0, rsp_data=0, busy=0, req_rdy=0, rr_ptr=0 (requester 0 has highest priority).
// - Transfer occurs on a req side when req_vld[i] && req_rdy[i]; on the rsp side when rsp_vld && rsp_rdy.
// - can_issue = !rsp_vld || rsp_rdy (output slot empty or draining this cycle).
// - Grant: combinational; first i with req_vld[i] searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
// - req_rdy[i] = can_issue && grant[i]; at most one bit high; req_rdy never depends on other requests' data.
// - On accept: rsp_data <= a*b, rsp_id <= i, rsp_vld <= 1 next edge; rr_ptr <= (i+1) mod NUM_REQ.
// - No accept: rr_ptr unchanged; if rsp drained, rsp_vld <= 0; rsp_data/rsp_id keep their last values.
// - Latency: accept at edge t -> rsp_vld high after edge t+1. Throughput: 1 per cycle with rsp_rdy=1.
// - Backpressure: while rsp_vld && !rsp_rdy, rsp_id/rsp_data are held stable and all req_rdy=0.
// - Simultaneous drain and accept in one cycle: the new result replaces the old with no bubble.
// - Requester may deassert req_vld without a transfer; no ordering promise beyond round-robin fairness.
// - Fairness: a continuously requesting requester waits at most NUM_REQ-1 grants.
// - busy = rsp_vld (| stage-1 valid when the pipe stage is enabled).
// - ap_rst mid-operation: all in-flight results are discarded; next cycle is identical to post-reset.
//
// CONFIGURATION
// - HESTONEURO_MUL_ARB_PIPE_EN defined: an operand register stage (s1_vld, s1_a, s1_b, s1_id) precedes the product register.
//   - Latency 2; can_issue = !s1_vld || (!rsp_vld || rsp_rdy); stage 1 advances under the same condition.
//   - Full throughput is kept; reset clears s1_vld.
// - Not defined: single-stage behaviour above (latency 1).
//
// TESTING
// - Single request: req_vld=0001, a=0x7FFF, b=0x7FFF -> req_rdy=0001 same cycle; next cycle rsp_vld=1, rsp_id=0, rsp_data=0x3FFF0001.
// - All four requesters valid continuously, rsp_rdy=1 -> grant order 0,1,2,3,0,1; one rsp per cycle; no bubbles.
// - Zero/one operands: a=0, b=0x1234 -> 0; a=1, b=0x7FFF -> 0x00007FFF.
// - Backpressure: rsp_rdy=0 for 3 cycles while rsp_vld -> rsp_data/rsp_id stable; req_rdy=0000; resumes with no loss.
// - Requesters 1 and 3 valid with rr_ptr=2 -> 3 granted first, then 1.
// - Reset mid-stream: assert ap_rst with rsp_vld=1 -> next cycle rsp_vld=0, busy=0, rr_ptr=0; first post-reset grant goes to the lowest valid index.
// - Run the full suite with and without HESTONEURO_MUL_ARB_PIPE_EN; expect the same results, with latency 2 vs 1.

Source files
------------

// File: rtl/hestoneuro_mul_arb_if.sv
// Request/response bundle between the hestonEuro requesters and the shared multiplier arbiter.
interface hestoneuro_mul_arb_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int OP_W    = 15,
    parameter int RES_W   = 30
);
    logic [NUM_REQ-1:0]      req_vld;
    logic [NUM_REQ-1:0]      req_rdy;
    logic [NUM_REQ*OP_W-1:0] req_a;
    logic [NUM_REQ*OP_W-1:0] req_b;
    logic                    rsp_vld;
    logic                    rsp_rdy;
    logic [ID_W-1:0]         rsp_id;
    logic [RES_W-1:0]        rsp_data;
    logic                    busy;

    modport master (
        output req_vld, req_a, req_b, rsp_rdy,
        input  req_rdy, rsp_vld, rsp_id, rsp_data, busy
    );

    modport slave (
        input  req_vld, req_a, req_b, rsp_rdy,
        output req_rdy, rsp_vld, rsp_id, rsp_data, busy
    );
endinterface

// File: rtl/hestoneuro_mul_arb.sv
// Round-robin shared 15x15 unsigned multiplier with a single id-tagged result port.
// Define HESTONEURO_MUL_ARB_PIPE_EN to add an operand register stage (latency 2 instead of 1).
module hestoneuro_mul_arb #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int OP_W    = 15,
    parameter int RES_W   = 30
) (
    input  logic                ap_clk,
    input  logic                ap_rst,
    hestoneuro_mul_arb_if.slave bus
);
    localparam logic [ID_W-1:0] LAST_IDX  = (ID_W)'(NUM_REQ - 1);
    localparam logic [ID_W:0]   NUM_REQ_X = (ID_W + 1)'(NUM_REQ);

    logic [ID_W-1:0]    r_rr_ptr;
    logic               r_rsp_vld;
    logic [ID_W-1:0]    r_rsp_id;
    logic [RES_W-1:0]   r_rsp_data;

    logic               w_gnt_found;
    logic [ID_W-1:0]    w_gnt_idx;
    logic [ID_W-1:0]    w_ptr_nxt;
    logic [NUM_REQ-1:0] w_req_rdy;
    logic               w_out_free;
    logic               w_can_issue;
    logic               w_accept;
    logic [OP_W-1:0]    w_sel_a;
    logic [OP_W-1:0]    w_sel_b;
    logic [RES_W-1:0]   w_prod;

    // Round-robin search from the pointer; the first valid requester in wrap order wins.
    always_comb begin
        logic [ID_W:0] w_sum;
        logic [ID_W:0] w_wrap;
        logic          w_hit;
        w_gnt_found = 1'b0;
        w_gnt_idx   = {ID_W{1'b0}};
        w_sum       = {(ID_W + 1){1'b0}};
        w_wrap      = {(ID_W + 1){1'b0}};
        w_hit       = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum       = {1'b0, r_rr_ptr} + (ID_W + 1)'(k);
            w_wrap      = (w_sum >= NUM_REQ_X) ? (w_sum - NUM_REQ_X) : w_sum;
            w_hit       = !w_gnt_found && bus.req_vld[w_wrap[ID_W-1:0]];
            w_gnt_idx   = w_hit ? w_wrap[ID_W-1:0] : w_gnt_idx;
            w_gnt_found = w_gnt_found | w_hit;
        end
    end

    assign w_ptr_nxt  = (w_gnt_idx == LAST_IDX) ? {ID_W{1'b0}} : (w_gnt_idx + (ID_W)'(1));
    assign w_sel_a    = bus.req_a[w_gnt_idx * OP_W +: OP_W];
    assign w_sel_b    = bus.req_b[w_gnt_idx * OP_W +: OP_W];
    assign w_out_free = !r_rsp_vld || bus.rsp_rdy;

    // Ready is held low during reset so nothing is accepted on the reset edge.
    assign w_req_rdy = (w_can_issue && w_gnt_found && !ap_rst) ?
                       ((NUM_REQ)'(1'b1) << w_gnt_idx) : {NUM_REQ{1'b0}};
    assign w_accept  = |w_req_rdy;

    // Pointer moves just past the winner only when a request is actually taken.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_rr_ptr <= {ID_W{1'b0}};
        end else if (w_accept) begin
            r_rr_ptr <= w_ptr_nxt;
        end else begin
            r_rr_ptr <= r_rr_ptr;
        end
    end

`ifdef HESTONEURO_MUL_ARB_PIPE_EN
    logic               r_s1_vld;
    logic [OP_W-1:0]    r_s1_a;
    logic [OP_W-1:0]    r_s1_b;
    logic [ID_W-1:0]    r_s1_id;

    // Stage 1 can take a new operand pair if it is empty or moving into the output slot.
    assign w_can_issue = !r_s1_vld || w_out_free;
    assign w_prod      = (RES_W)'(r_s1_a) * (RES_W)'(r_s1_b);

    // Operand stage: capture the granted pair, empty out when it advances without refill.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_s1_vld <= 1'b0;
            r_s1_a   <= {OP_W{1'b0}};
            r_s1_b   <= {OP_W{1'b0}};
            r_s1_id  <= {ID_W{1'b0}};
        end else if (w_accept) begin
            r_s1_vld <= 1'b1;
            r_s1_a   <= w_sel_a;
            r_s1_b   <= w_sel_b;
            r_s1_id  <= w_gnt_idx;
        end else if (w_out_free) begin
            r_s1_vld <= 1'b0;
        end else begin
            r_s1_vld <= r_s1_vld;
        end
    end

    // Output slot: takes the stage-1 product whenever the slot is free or draining.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_rsp_vld  <= 1'b0;
            r_rsp_id   <= {ID_W{1'b0}};
            r_rsp_data <= {RES_W{1'b0}};
        end else if (w_out_free) begin
            r_rsp_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_rsp_id   <= r_s1_id;
                r_rsp_data <= w_prod;
            end else begin
                r_rsp_id   <= r_rsp_id;
                r_rsp_data <= r_rsp_data;
            end
        end else begin
            r_rsp_vld <= r_rsp_vld;
        end
    end

    assign bus.busy = r_rsp_vld | r_s1_vld;
`else
    assign w_can_issue = w_out_free;
    assign w_prod      = (RES_W)'(w_sel_a) * (RES_W)'(w_sel_b);

    // Output slot: a new product replaces a draining one with no bubble; id/data hold otherwise.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_rsp_vld  <= 1'b0;
            r_rsp_id   <= {ID_W{1'b0}};
            r_rsp_data <= {RES_W{1'b0}};
        end else if (w_accept) begin
            r_rsp_vld  <= 1'b1;
            r_rsp_id   <= w_gnt_idx;
            r_rsp_data <= w_prod;
        end else if (bus.rsp_rdy) begin
            r_rsp_vld <= 1'b0;
        end else begin
            r_rsp_vld <= r_rsp_vld;
        end
    end

    assign bus.busy = r_rsp_vld;
`endif

    assign bus.req_rdy  = w_req_rdy;
    assign bus.rsp_vld  = r_rsp_vld;
    assign bus.rsp_id   = r_rsp_id;
    assign bus.rsp_data = r_rsp_data;
endmodule

// File: tb/tb_hestoneuro_mul_arb.sv
// Self-checking bench for hestoneuro_mul_arb: vector table, directed corner cases, random traffic vs a queue model.
module tb_hestoneuro_mul_arb;
`ifdef HESTONEURO_MUL_ARB_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        int          id;
        longint      dat;
        int          age;
    } item_t;

    typedef struct {
        int          id;
        logic [14:0] a;
        logic [14:0] b;
        logic [29:0] exp;
    } vec_t;

    logic ap_clk = 1'b0;
    logic ap_rst;

    hestoneuro_mul_arb_if #(.NUM_REQ(4), .ID_W(2), .OP_W(15), .RES_W(30)) bus ();

    hestoneuro_mul_arb #(.NUM_REQ(4), .ID_W(2), .OP_W(15), .RES_W(30)) dut (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .bus    (bus)
    );

    always #5 ap_clk = ~ap_clk;

    int          n_chk = 0;
    int          n_err = 0;
    item_t       m_q[$];
    int          m_ptr = 0;
    logic        obs_vld;
    logic        obs_busy;
    logic [3:0]  obs_rdy;
    logic [1:0]  obs_id;
    logic [29:0] obs_data;
    vec_t        tbl[6];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [59:0] rnd60();
        return 60'({$urandom(), $urandom()});
    endfunction

    function automatic logic [59:0] put(input logic [59:0] base, input int id, input logic [14:0] v);
        logic [59:0] r;
        r = base;
        r[id*15 +: 15] = v;
        return r;
    endfunction

    // One clock: drive, compare against the model, advance model across the edge.
    task automatic step(input logic [3:0] vld, input logic [59:0] a, input logic [59:0] b, input logic rdy);
        logic       e_vld;
        logic       e_busy;
        logic       e_issue;
        logic [3:0] e_rdy;
        int         e_gnt;
        bus.req_vld = vld;
        bus.req_a   = a;
        bus.req_b   = b;
        bus.rsp_rdy = rdy;
        #3;
        e_vld   = (m_q.size() > 0) && (m_q[0].age >= LAT);
        e_busy  = (m_q.size() > 0);
        e_issue = (m_q.size() < LAT) || (e_vld && rdy);
        e_gnt   = -1;
        for (int k = 0; k < 4; k++) begin
            if (e_gnt < 0 && vld[(m_ptr + k) % 4]) e_gnt = (m_ptr + k) % 4;
        end
        e_rdy = (e_issue && e_gnt >= 0) ? (4'b0001 << e_gnt) : 4'b0000;
        obs_vld  = bus.rsp_vld;
        obs_busy = bus.busy;
        obs_rdy  = bus.req_rdy;
        obs_id   = bus.rsp_id;
        obs_data = bus.rsp_data;
        chk("rsp_vld", longint'(obs_vld), longint'(e_vld));
        chk("busy", longint'(obs_busy), longint'(e_busy));
        chk("req_rdy", longint'(obs_rdy), longint'(e_rdy));
        if (e_vld) begin
            chk("rsp_id", longint'(obs_id), longint'(m_q[0].id));
            chk("rsp_data", longint'(obs_data), m_q[0].dat);
        end
        @(posedge ap_clk);
        if (e_vld && rdy) void'(m_q.pop_front());
        if (e_rdy != 4'b0000) begin
            m_q.push_back('{e_gnt, longint'(a[e_gnt*15 +: 15]) * longint'(b[e_gnt*15 +: 15]), 0});
            m_ptr = (e_gnt + 1) % 4;
        end
        foreach (m_q[i]) m_q[i].age++;
        #1;
    endtask

    task automatic do_reset(input logic [3:0] vld);
        ap_rst      = 1'b1;
        bus.req_vld = vld;
        bus.req_a   = rnd60();
        bus.req_b   = rnd60();
        bus.rsp_rdy = 1'b0;
        #3;
        chk("rst_req_rdy", longint'(bus.req_rdy), 0);
        @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        m_q.delete();
        m_ptr = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(4'b0000, rnd60(), rnd60(), 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        tbl[0] = '{0, 15'h7FFF, 15'h7FFF, 30'h3FFF0001};
        tbl[1] = '{1, 15'h0000, 15'h1234, 30'h00000000};
        tbl[2] = '{2, 15'h0001, 15'h7FFF, 30'h00007FFF};
        tbl[3] = '{3, 15'h1234, 15'h0010, 30'h00012340};
        tbl[4] = '{0, 15'h7FFF, 15'h0001, 30'h00007FFF};
        tbl[5] = '{2, 15'h4000, 15'h4000, 30'h10000000};

        ap_rst      = 1'b1;
        bus.req_vld = 4'b0000;
        bus.req_a   = 60'd0;
        bus.req_b   = 60'd0;
        bus.rsp_rdy = 1'b0;
        @(posedge ap_clk);
        #1;
        do_reset(4'b1111);

        step(4'b0000, rnd60(), rnd60(), 1'b1);
        chk("reset_rsp_vld", longint'(obs_vld), 0);
        chk("reset_busy", longint'(obs_busy), 0);
        chk("reset_rsp_id", longint'(obs_id), 0);
        chk("reset_rsp_data", longint'(obs_data), 0);

        // Single requests from the vector table.
        for (int t = 0; t < 6; t++) begin
            step(4'b0001 << tbl[t].id, put(rnd60(), tbl[t].id, tbl[t].a),
                 put(rnd60(), tbl[t].id, tbl[t].b), 1'b1);
            chk("tbl_req_rdy", longint'(obs_rdy), longint'(4'b0001 << tbl[t].id));
            seen = 1'b0;
            for (int w = 0; w < LAT + 2 && !seen; w++) begin
                step(4'b0000, rnd60(), rnd60(), 1'b1);
                if (obs_vld) begin
                    seen = 1'b1;
                    chk("tbl_rsp_id", longint'(obs_id), longint'(tbl[t].id));
                    chk("tbl_rsp_data", longint'(obs_data), longint'(tbl[t].exp));
                end
            end
            if (!seen) chk("tbl_timeout", 0, 1);
        end

        // All four streaming with a ready consumer: strict rotation, no bubbles.
        do_reset(4'b0000);
        for (int i = 0; i < 8; i++) begin
            step(4'b1111, rnd60(), rnd60(), 1'b1);
            chk("rr_order", longint'(obs_rdy), longint'(4'b0001 << (i % 4)));
            if (i >= LAT) chk("no_bubble", longint'(obs_vld), 1);
        end

        // Backpressure: result held, nothing accepted, then drain without loss.
        for (int i = 0; i < 3; i++) begin
            step(4'b1111, rnd60(), rnd60(), 1'b0);
            chk("bp_req_rdy", longint'(obs_rdy), 0);
            chk("bp_rsp_vld", longint'(obs_vld), 1);
        end
        idle(LAT + 2);
        chk("bp_drained", longint'(obs_busy), 0);

        // Pointer at 2 with requesters 1 and 3 pending: 3 first, then 1.
        do_reset(4'b0000);
        step(4'b0010, rnd60(), rnd60(), 1'b1);
        step(4'b1010, rnd60(), rnd60(), 1'b1);
        chk("ptr2_first", longint'(obs_rdy), 4'b1000);
        step(4'b1010, rnd60(), rnd60(), 1'b1);
        chk("ptr2_second", longint'(obs_rdy), 4'b0010);
        idle(LAT + 2);

        // Reset while a result is waiting.
        step(4'b0001, rnd60(), rnd60(), 1'b0);
        for (int i = 0; i < LAT; i++) step(4'b0000, rnd60(), rnd60(), 1'b0);
        chk("pre_rst_rsp_vld", longint'(obs_vld), 1);
        do_reset(4'b1110);
        step(4'b1110, rnd60(), rnd60(), 1'b1);
        chk("post_rst_rsp_vld", longint'(obs_vld), 0);
        chk("post_rst_busy", longint'(obs_busy), 0);
        chk("post_rst_grant", longint'(obs_rdy), 4'b0010);
        idle(LAT + 2);

        // Random traffic with random backpressure and occasional reset.
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 63) == 0) do_reset(4'($urandom_range(0, 15)));
            step(4'($urandom_range(0, 15)), rnd60(), rnd60(), ($urandom_range(0, 3) != 0));
        end
        idle(LAT + 3);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
